axi_txn_scheduler: RTL and testbench
====================================

Name: axi_txn_scheduler

Overview:
Sits between the command decoder and AXI_Master. It arbitrates read/write burst commands from NUM_REQ requesters with round-robin priority and issues them as single-cycle wr_trn_en/rd_trn_en pulses, with a stable command bus. It tracks outstanding write and read transactions against MAX_OUTST per direction. Completions (B, R-last) are routed back to the originating requester by transaction ID.

Parameters:
NUM_REQ, 4, number of requesters (power of 2, 2..8)
ADDR_W, 32, address width
LEN_W, 4, burst length field width (beats-1)
ID_W, 4, transaction ID width presented to AXI_Master
RSP_W, 2, response code width
MAX_OUTST, 4, max outstanding transactions per direction (1..15)

Ports:
ACLK  in  1  clock
ARESETn  in  1  reset
req_valid  in  NUM_REQ  command pending, per requester
req_rw  in  NUM_REQ  1=write, 0=read, per requester
req_addr  in  NUM_REQ*ADDR_W  packed start addresses, requester i at [i*ADDR_W +: ADDR_W]
req_len  in  NUM_REQ*LEN_W  packed burst lengths
req_ready  out  NUM_REQ  one-cycle accept pulse
req_done  out  NUM_REQ  one-cycle completion pulse
req_err  out  NUM_REQ  qualifies req_done: response != OKAY
trn_addr  out  ADDR_W  issued address, held until trn_ack
trn_len  out  LEN_W  issued length, held until trn_ack
trn_id  out  ID_W  issued ID = requester index, zero-extended
wr_trn_en  out  1  write issue pulse
rd_trn_en  out  1  read issue pulse
trn_ack  in  1  AXI_Master address handshake done (AW or AR)
wr_rsp_en  in  1  write response valid
bid  in  ID_W  write response ID
bresp  in  RSP_W  write response code
rd_rsp_en  in  1  read beat valid
rlast  in  1  last read beat
rid  in  ID_W  read ID
rresp  in  RSP_W  read response code
wr_outst  out  4  outstanding write count
rd_outst  out  4  outstanding read count
protocol_err  out  1  sticky: unexpected response

Behaviour:
- Single clock ACLK; reset ARESETn synchronous, active-low.
- Reset values: all outputs 0, state IDLE, RR pointer 0, counters 0, accumulated read error 0.
- FSM states: IDLE, WAIT_ACK.
- IDLE: the eligible set is the req_valid bits whose direction count < MAX_OUTST. Pick the first eligible index at or after the RR pointer, wrapping around.
- On a pick: next cycle req_ready[i]=1, the matching wr_/rd_trn_en=1 (one cycle), trn_* loaded, state goes to WAIT_ACK, and the RR pointer moves to i+1 mod NUM_REQ.
- Latency is therefore 1 cycle from req_valid to issue.
- If no requester is eligible, stay in IDLE; the pointer does not move.
- WAIT_ACK: hold trn_addr/len/id stable, trn_en low. On trn_ack go to IDLE; the next grant comes no earlier than the following cycle.
- trn_ack asserted in the same cycle as the trn_en pulse is legal and is honoured.
- A requester must hold req_valid and its command until req_ready. req_valid dropping before grant is legal; the request is simply not picked.
- Counters: increment on trn_en pulse; wr_outst decrements on wr_rsp_en; rd_outst decrements on rd_rsp_en&&rlast. Increment and decrement in the same cycle leave the count unchanged. Counts never exceed MAX_OUTST.
- Write completion: on wr_rsp_en, req_done[bid]=1 next cycle and req_err[bid]=(bresp!=0).
- Read completion: read error accumulates (OR of rresp!=0) across the beats of a burst. On the rlast beat, req_done[rid]=1 next cycle and req_err = accumulated | current; the accumulator then clears.
- Concurrent B and R completions to different IDs both pulse in the same cycle. For the same ID, both pulse req_done; req_err is the OR.
- protocol_err is set (sticky until reset), and the response is otherwise ignored with no done and no decrement, when:
  - the ID is >= NUM_REQ; or
  - the response arrives while the direction count is 0.
- Reset asserted mid-operation: pending pulses are dropped, counters clear, state returns to IDLE, and in-flight completions are lost.

Decomposition:
- Shared package: AXI response codes (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3), FSM state typedef, RW direction constants.
- One sub-module: rr_arbiter (NUM_REQ-wide request/mask in, one-hot grant + index out, pointer update input). Keep the counters and FSM in the top level.

Test Plan:
- Single write: req_valid[0]=1, rw=1, addr=0x1000, len=3 -> next cycle wr_trn_en=1, req_ready[0]=1, trn_id=0, wr_outst=1. trn_ack, then wr_rsp_en with bid=0, bresp=0 -> req_done[0]=1, req_err=0, wr_outst=0.
- Round-robin: all 4 requesters valid for reads, trn_ack same cycle -> grant order 0,1,2,3,0. Each issue is 2 cycles apart.
- Outstanding limit: 5 writes, no responses -> 4 issued, wr_outst=4, 5th stalls. One wr_rsp_en -> 5th issues, wr_outst stays 4 (simultaneous inc/dec case covered when aligned).
- Read error accumulation: len=3 burst, rid=2, rresp = 0,2,0,0 with rlast on beat 4 -> req_done[2]=1 with req_err[2]=1. The next burst with all OKAY -> req_err=0.
- Protocol error: wr_rsp_en while wr_outst=0, then bid=7 with NUM_REQ=4 -> protocol_err=1 and sticky, no req_done, counters unchanged.
- Reset mid-operation: ARESETn=0 during WAIT_ACK with rd_outst=2 -> next cycle all outputs 0, state IDLE. Next request issues normally with trn_id per grant.

Source files
------------

// File: rtl/axi_txn_scheduler_pkg.sv
// Shared types for the AXI transaction scheduler: response codes, FSM states,
// command direction and the outstanding-counter width.
package axi_txn_scheduler_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_e;

  typedef enum logic {
    DIR_READ  = 1'b0,
    DIR_WRITE = 1'b1
  } dir_e;

  localparam int CNT_W = 4;

endpackage

// File: rtl/axi_txn_scheduler_if.sv
// Requester command bus, AXI_Master issue/response side and status of the scheduler.
interface axi_txn_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 4,
  parameter int ID_W    = 4,
  parameter int RSP_W   = 2
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_rw;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_done;
  logic [NUM_REQ-1:0]        req_err;
  logic [ADDR_W-1:0]         trn_addr;
  logic [LEN_W-1:0]          trn_len;
  logic [ID_W-1:0]           trn_id;
  logic                      wr_trn_en;
  logic                      rd_trn_en;
  logic                      trn_ack;
  logic                      wr_rsp_en;
  logic [ID_W-1:0]           bid;
  logic [RSP_W-1:0]          bresp;
  logic                      rd_rsp_en;
  logic                      rlast;
  logic [ID_W-1:0]           rid;
  logic [RSP_W-1:0]          rresp;
  logic [3:0]                wr_outst;
  logic [3:0]                rd_outst;
  logic                      protocol_err;

  modport master (
    output req_valid, req_rw, req_addr, req_len, trn_ack,
           wr_rsp_en, bid, bresp, rd_rsp_en, rlast, rid, rresp,
    input  req_ready, req_done, req_err, trn_addr, trn_len, trn_id,
           wr_trn_en, rd_trn_en, wr_outst, rd_outst, protocol_err
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_len, trn_ack,
           wr_rsp_en, bid, bresp, rd_rsp_en, rlast, rid, rresp,
    output req_ready, req_done, req_err, trn_addr, trn_len, trn_id,
           wr_trn_en, rd_trn_en, wr_outst, rd_outst, protocol_err
  );
endinterface

// File: rtl/axi_txn_scheduler_rr_arbiter.sv
// Round-robin arbiter: first request that is also unmasked, searching upward
// from the pointer with wrap; the pointer moves past the winner on update_i.
module axi_txn_scheduler_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] mask_i,
  input  logic               update_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr_q + IDX_W'(k);
      if (!any_o && req_i[cand] && mask_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

  assign ptr_d = update_i ? idx_o + IDX_W'(1) : ptr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
endmodule

// File: rtl/axi_txn_scheduler.sv
// Round-robin scheduler issuing requester bursts to AXI_Master and routing
// B / R-last completions back to the requester named by the transaction ID.
module axi_txn_scheduler
  import axi_txn_scheduler_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 4,
  parameter int ID_W      = 4,
  parameter int RSP_W     = 2,
  parameter int MAX_OUTST = 4
) (
  input logic ACLK,
  input logic ARESETn,
  axi_txn_scheduler_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);
  localparam logic [ID_W-1:0]  NUM_ID  = ID_W'(NUM_REQ);

  state_e             state_q;
  logic [NUM_REQ-1:0] elig, gnt;
  logic [IDX_W-1:0]   gnt_idx, bidx, ridx;
  logic               gnt_any, pick, pick_wr, pick_rd;
  logic               wr_ok, rd_ok, wr_dec, rd_dec, wr_bad, rd_bad;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic [NUM_REQ-1:0] rd_acc_q, rd_acc_d, done_q, done_d, err_q, err_d, ready_q;
  logic               wr_en_q, rd_en_q, perr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   len_q;
  logic [ID_W-1:0]    id_q;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = (bus.req_rw[i] == DIR_WRITE) ? (wr_cnt_q < MAX_CNT) : (rd_cnt_q < MAX_CNT);
  end

  axi_txn_scheduler_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_i    (ACLK),
    .rst_ni   (ARESETn),
    .req_i    (bus.req_valid),
    .mask_i   (elig),
    .update_i (pick),
    .gnt_o    (gnt),
    .idx_o    (gnt_idx),
    .any_o    (gnt_any)
  );

  assign pick    = (state_q == ST_IDLE) && gnt_any;
  assign pick_wr = pick && (bus.req_rw[gnt_idx] == DIR_WRITE);
  assign pick_rd = pick && (bus.req_rw[gnt_idx] == DIR_READ);

  // A response is only honoured for a real requester with something in flight.
  assign bidx   = bus.bid[IDX_W-1:0];
  assign ridx   = bus.rid[IDX_W-1:0];
  assign wr_ok  = bus.wr_rsp_en && (bus.bid < NUM_ID) && (wr_cnt_q != '0);
  assign rd_ok  = bus.rd_rsp_en && (bus.rid < NUM_ID) && (rd_cnt_q != '0);
  assign wr_bad = bus.wr_rsp_en && !wr_ok;
  assign rd_bad = bus.rd_rsp_en && !rd_ok;
  assign wr_dec = wr_ok;
  assign rd_dec = rd_ok && bus.rlast;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (pick_wr && !wr_dec)      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    else if (!pick_wr && wr_dec) wr_cnt_d = wr_cnt_q - CNT_W'(1);
    if (pick_rd && !rd_dec)      rd_cnt_d = rd_cnt_q + CNT_W'(1);
    else if (!pick_rd && rd_dec) rd_cnt_d = rd_cnt_q - CNT_W'(1);
  end

  always_comb begin
    done_d   = '0;
    err_d    = '0;
    rd_acc_d = rd_acc_q;
    if (wr_ok) begin
      done_d[bidx] = 1'b1;
      err_d[bidx]  = (bus.bresp != RSP_W'(RESP_OKAY));
    end
    if (rd_ok) begin
      if (bus.rlast) begin
        done_d[ridx]   = 1'b1;
        err_d[ridx]    = err_d[ridx] | rd_acc_q[ridx] | (bus.rresp != RSP_W'(RESP_OKAY));
        rd_acc_d[ridx] = 1'b0;
      end else begin
        rd_acc_d[ridx] = rd_acc_q[ridx] | (bus.rresp != RSP_W'(RESP_OKAY));
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q  <= ST_IDLE;
      ready_q  <= '0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      id_q     <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      done_q   <= '0;
      err_q    <= '0;
      rd_acc_q <= '0;
      perr_q   <= 1'b0;
    end else begin
      ready_q <= '0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick) begin
            ready_q <= gnt;
            wr_en_q <= pick_wr;
            rd_en_q <= pick_rd;
            addr_q  <= bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
            len_q   <= bus.req_len[gnt_idx*LEN_W +: LEN_W];
            id_q    <= ID_W'(gnt_idx);
            state_q <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: if (bus.trn_ack) state_q <= ST_IDLE;
        default:     state_q <= ST_IDLE;
      endcase
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rd_acc_q <= rd_acc_d;
      perr_q   <= perr_q | wr_bad | rd_bad;
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.req_done     = done_q;
  assign bus.req_err      = err_q;
  assign bus.trn_addr     = addr_q;
  assign bus.trn_len      = len_q;
  assign bus.trn_id       = id_q;
  assign bus.wr_trn_en    = wr_en_q;
  assign bus.rd_trn_en    = rd_en_q;
  assign bus.wr_outst     = wr_cnt_q;
  assign bus.rd_outst     = rd_cnt_q;
  assign bus.protocol_err = perr_q;
endmodule

// File: tb/tb_axi_txn_scheduler.sv
// Directed and randomized bench for axi_txn_scheduler against a cycle-level
// behavioural model of the arbitration, counting and completion rules.
module tb_axi_txn_scheduler;
  localparam int NUM_REQ   = 4;
  localparam int ADDR_W    = 32;
  localparam int LEN_W     = 4;
  localparam int ID_W      = 4;
  localparam int RSP_W     = 2;
  localparam int MAX_OUTST = 4;

  logic ACLK;
  logic ARESETn;
  int   tests = 0;
  int   fails = 0;

  axi_txn_scheduler_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W),
                         .ID_W(ID_W), .RSP_W(RSP_W)) bus ();

  axi_txn_scheduler #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .ID_W(ID_W),
                      .RSP_W(RSP_W), .MAX_OUTST(MAX_OUTST)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  // Reference model state
  int                 m_wr, m_rd, m_ptr;
  bit                 m_busy, m_perr;
  bit [NUM_REQ-1:0]   m_acc;
  logic [NUM_REQ-1:0] e_ready, e_done, e_err;
  logic               e_wr, e_rd;
  logic [ADDR_W-1:0]  e_addr;
  logic [LEN_W-1:0]   e_len;
  logic [ID_W-1:0]    e_id;
  int                 wq[$];
  int                 rq[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_ptr = 0; m_busy = 0; m_perr = 0; m_acc = '0;
    e_ready = '0; e_done = '0; e_err = '0; e_wr = 0; e_rd = 0;
    e_addr = '0; e_len = '0; e_id = '0;
    wq.delete(); rq.delete();
  endtask

  task automatic model_eval();
    int  wdec, rdec, winc, rinc, id;
    bit  cur, granted;
    wdec = 0; rdec = 0; winc = 0; rinc = 0; granted = 0;
    if (!ARESETn) begin
      model_reset();
      return;
    end
    e_ready = '0; e_done = '0; e_err = '0; e_wr = 0; e_rd = 0;
    if (bus.wr_rsp_en) begin
      id = int'(bus.bid);
      if (id < NUM_REQ && m_wr > 0) begin
        e_done[id] = 1; e_err[id] = (bus.bresp != 0); wdec = 1;
      end else m_perr = 1;
    end
    if (bus.rd_rsp_en) begin
      id = int'(bus.rid);
      if (id < NUM_REQ && m_rd > 0) begin
        cur = (bus.rresp != 0);
        if (bus.rlast) begin
          e_done[id] = 1; e_err[id] = e_err[id] | m_acc[id] | cur; m_acc[id] = 0; rdec = 1;
        end else m_acc[id] = m_acc[id] | cur;
      end else m_perr = 1;
    end
    if (!m_busy) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        int i;
        i = (m_ptr + k) % NUM_REQ;
        if (!granted && bus.req_valid[i] &&
            (bus.req_rw[i] ? (m_wr < MAX_OUTST) : (m_rd < MAX_OUTST))) begin
          granted    = 1;
          e_ready[i] = 1;
          e_addr     = bus.req_addr[i*ADDR_W +: ADDR_W];
          e_len      = bus.req_len[i*LEN_W +: LEN_W];
          e_id       = ID_W'(i);
          if (bus.req_rw[i]) begin e_wr = 1; winc = 1; wq.push_back(i); end
          else begin e_rd = 1; rinc = 1; rq.push_back(i); end
          m_busy = 1;
          m_ptr  = (i + 1) % NUM_REQ;
        end
      end
    end else if (bus.trn_ack) m_busy = 0;
    m_wr = m_wr + winc - wdec;
    m_rd = m_rd + rinc - rdec;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".req_ready"}, 64'(bus.req_ready), 64'(e_ready));
    chk({tag, ".wr_trn_en"}, 64'(bus.wr_trn_en), 64'(e_wr));
    chk({tag, ".rd_trn_en"}, 64'(bus.rd_trn_en), 64'(e_rd));
    chk({tag, ".req_done"}, 64'(bus.req_done), 64'(e_done));
    chk({tag, ".req_err"}, 64'(bus.req_err), 64'(e_err));
    chk({tag, ".trn_addr"}, 64'(bus.trn_addr), 64'(e_addr));
    chk({tag, ".trn_len"}, 64'(bus.trn_len), 64'(e_len));
    chk({tag, ".trn_id"}, 64'(bus.trn_id), 64'(e_id));
    chk({tag, ".wr_outst"}, 64'(bus.wr_outst), 64'(m_wr));
    chk({tag, ".rd_outst"}, 64'(bus.rd_outst), 64'(m_rd));
    chk({tag, ".protocol_err"}, 64'(bus.protocol_err), 64'(m_perr));
  endtask

  task automatic cycle(input string tag);
    model_eval();
    @(posedge ACLK);
    #1;
    check_all(tag);
    bus.wr_rsp_en = 0;
    bus.rd_rsp_en = 0;
    bus.rlast     = 0;
    for (int i = 0; i < NUM_REQ; i++) if (e_ready[i]) bus.req_valid[i] = 0;
  endtask

  task automatic set_req(input int i, input logic rw, input logic [ADDR_W-1:0] a,
                         input logic [LEN_W-1:0] l);
    bus.req_valid[i] = 1;
    bus.req_rw[i]    = rw;
    bus.req_addr[i*ADDR_W +: ADDR_W] = a;
    bus.req_len[i*LEN_W +: LEN_W]    = l;
  endtask

  logic [RSP_W-1:0] beat_rsp [4];

  initial begin
    ARESETn = 0;
    bus.req_valid = '0; bus.req_rw = '0; bus.req_addr = '0; bus.req_len = '0;
    bus.trn_ack = 0; bus.wr_rsp_en = 0; bus.bid = '0; bus.bresp = '0;
    bus.rd_rsp_en = 0; bus.rlast = 0; bus.rid = '0; bus.rresp = '0;
    model_reset();
    cycle("reset0");
    cycle("reset1");
    chk("reset.state_outputs", 64'({bus.req_ready, bus.wr_trn_en, bus.rd_trn_en, bus.wr_outst}), 64'(0));
    ARESETn = 1;

    // Single write
    set_req(0, 1'b1, 32'h1000, 4'd3);
    cycle("wr1_issue");
    chk("wr1.wr_trn_en", 64'(bus.wr_trn_en), 64'(1));
    chk("wr1.req_ready", 64'(bus.req_ready), 64'(4'b0001));
    chk("wr1.trn_addr", 64'(bus.trn_addr), 64'(32'h1000));
    chk("wr1.wr_outst", 64'(bus.wr_outst), 64'(1));
    bus.trn_ack = 1;
    cycle("wr1_ack");
    bus.trn_ack = 0;
    bus.wr_rsp_en = 1; bus.bid = 0; bus.bresp = 0;
    cycle("wr1_bresp");
    chk("wr1.req_done", 64'(bus.req_done), 64'(4'b0001));
    chk("wr1.req_err", 64'(bus.req_err), 64'(0));
    chk("wr1.wr_outst_after", 64'(bus.wr_outst), 64'(0));

    // Round-robin across four readers, ack in the issue cycle
    ARESETn = 0;
    cycle("rr_reset");
    ARESETn = 1;
    bus.trn_ack = 1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (!bus.req_valid[i]) set_req(i, 1'b0, $urandom, LEN_W'($urandom));
      cycle("rr_issue");
      chk("rr.order", 64'(bus.trn_id), 64'(k % NUM_REQ));
      chk("rr.rd_trn_en", 64'(bus.rd_trn_en), 64'(1));
      bus.rd_rsp_en = 1; bus.rlast = 1; bus.rid = ID_W'(k % NUM_REQ); bus.rresp = 0;
      cycle("rr_gap");
      chk("rr.gap_no_issue", 64'(bus.rd_trn_en), 64'(0));
    end
    bus.req_valid = '0;

    // Outstanding write limit
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 32'h4000 + 32'(i), 4'd1);
    for (int c = 0; c < 8; c++) cycle("lim_fill");
    set_req(1, 1'b1, 32'h5000, 4'd2);
    for (int c = 0; c < 3; c++) cycle("lim_stall");
    chk("lim.wr_outst_max", 64'(bus.wr_outst), 64'(4));
    chk("lim.stalled", 64'(bus.wr_trn_en), 64'(0));
    bus.wr_rsp_en = 1; bus.bid = 1; bus.bresp = 0;
    cycle("lim_rsp");
    cycle("lim_issue5");
    chk("lim.fifth_issue", 64'(bus.wr_trn_en), 64'(1));
    chk("lim.fifth_outst", 64'(bus.wr_outst), 64'(4));
    bus.wr_rsp_en = 1; bus.bid = 2; bus.bresp = 0;
    set_req(2, 1'b1, 32'h6000, 4'd0);
    cycle("lim_dec");
    bus.wr_rsp_en = 1; bus.bid = 3; bus.bresp = RSP_W'(2);
    cycle("lim_incdec");
    chk("lim.incdec_outst", 64'(bus.wr_outst), 64'(3));
    chk("lim.incdec_issue", 64'(bus.trn_id), 64'(2));
    chk("lim.slverr", 64'(bus.req_err), 64'(4'b1000));
    for (int b = 0; b < 3; b++) begin
      bus.wr_rsp_en = 1; bus.bid = ID_W'(b); bus.bresp = 0;
      cycle("lim_drain");
    end

    // Read error accumulation across beats
    beat_rsp[0] = 0; beat_rsp[1] = 2; beat_rsp[2] = 0; beat_rsp[3] = 0;
    for (int burst = 0; burst < 2; burst++) begin
      set_req(2, 1'b0, 32'h2000, 4'd3);
      cycle("racc_issue");
      chk("racc.rd_trn_en", 64'(bus.rd_trn_en), 64'(1));
      for (int b = 0; b < 4; b++) begin
        bus.rd_rsp_en = 1; bus.rid = 2; bus.rlast = (b == 3);
        bus.rresp = (burst == 0) ? beat_rsp[b] : RSP_W'(0);
        cycle("racc_beat");
      end
      chk("racc.done", 64'(bus.req_done), 64'(4'b0100));
      chk("racc.err", 64'(bus.req_err), (burst == 0) ? 64'(4'b0100) : 64'(0));
      chk("racc.rd_outst", 64'(bus.rd_outst), 64'(0));
    end

    // Protocol errors
    bus.wr_rsp_en = 1; bus.bid = 0; bus.bresp = 0;
    cycle("perr_zero_cnt");
    chk("perr.zero_cnt", 64'(bus.protocol_err), 64'(1));
    chk("perr.no_done", 64'(bus.req_done), 64'(0));
    bus.wr_rsp_en = 1; bus.bid = 7;
    cycle("perr_bad_id");
    set_req(0, 1'b1, 32'h7000, 4'd1);
    cycle("perr_wr_issue");
    bus.wr_rsp_en = 1; bus.bid = 7;
    cycle("perr_bad_id_busy");
    chk("perr.bad_id_cnt", 64'(bus.wr_outst), 64'(1));
    chk("perr.bad_id_done", 64'(bus.req_done), 64'(0));
    bus.rd_rsp_en = 1; bus.rlast = 1; bus.rid = 5;
    cycle("perr_rd");
    bus.wr_rsp_en = 1; bus.bid = 0; bus.bresp = 0;
    cycle("perr_drain");
    chk("perr.drain_done", 64'(bus.req_done), 64'(4'b0001));
    cycle("perr_idle");
    chk("perr.sticky", 64'(bus.protocol_err), 64'(1));

    // Reset while waiting for ack with two reads outstanding
    bus.trn_ack = 0;
    set_req(0, 1'b0, 32'h8000, 4'd1);
    set_req(1, 1'b0, 32'h8100, 4'd2);
    cycle("mrst_issue_a");
    bus.trn_ack = 1;
    cycle("mrst_ack_a");
    bus.trn_ack = 0;
    cycle("mrst_issue_b");
    chk("mrst.rd_outst2", 64'(bus.rd_outst), 64'(2));
    ARESETn = 0;
    cycle("mrst_reset");
    chk("mrst.cleared", 64'({bus.rd_outst, bus.protocol_err, bus.trn_id, bus.rd_trn_en}), 64'(0));
    chk("mrst.addr", 64'(bus.trn_addr), 64'(0));
    ARESETn = 1;
    set_req(3, 1'b1, 32'h3000, 4'd1);
    bus.trn_ack = 1;
    cycle("mrst_after");
    chk("mrst.id", 64'(bus.trn_id), 64'(3));
    chk("mrst.wr_en", 64'(bus.wr_trn_en), 64'(1));

    // Randomized traffic
    ARESETn = 0;
    bus.req_valid = '0;
    cycle("rand_reset");
    ARESETn = 1;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!bus.req_valid[i]) begin
          if ($urandom % 3 == 0) set_req(i, 1'($urandom), $urandom, LEN_W'($urandom));
        end else if ($urandom % 20 == 0) bus.req_valid[i] = 0;
      end
      bus.trn_ack = 1'($urandom);
      if (wq.size() > 0 && $urandom % 3 == 0) begin
        int idx;
        idx = int'($urandom_range(0, wq.size() - 1));
        bus.wr_rsp_en = 1; bus.bid = ID_W'(wq[idx]); bus.bresp = RSP_W'($urandom);
        wq.delete(idx);
      end
      if (rq.size() > 0 && $urandom % 2 == 0) begin
        bus.rd_rsp_en = 1; bus.rid = ID_W'(rq[0]);
        bus.rresp = ($urandom % 4 == 0) ? RSP_W'($urandom) : RSP_W'(0);
        bus.rlast = ($urandom % 3 == 0);
        if (bus.rlast) void'(rq.pop_front());
      end
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
